// File: rtl/stream_controller_pkg.sv
// rtl/stream_controller_pkg.sv - shared state encodings and framing helper for stream_controller
package stream_controller_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    // A start-of-frame marker is legal exactly at the raster origin.
    function automatic logic sof_mismatch(input logic sof, input logic at_origin);
        return sof != at_origin;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster-order x/y counter with wrap at frame end
module raster_counter #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int COORD_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT - 1);

    assign last = (x == X_MAX) && (y == Y_MAX);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + COORD_W'(1);
            end else begin
                x <= x + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/stream_controller.sv
// rtl/stream_controller.sv - frame sequencer feeding the pixel pipeline and tracking fill latency
module stream_controller
    import stream_controller_pkg::*;
#(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int LATENCY      = FRAME_WIDTH + 2,
    parameter int PIXEL_SIZE   = 24,
    parameter int COORD_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [PIXEL_SIZE-1:0] in_data,
    output logic                  pipe_en,
    output logic                  pipe_hsync,
    output logic                  pipe_vsync,
    output logic [PIXEL_SIZE-1:0] pipe_data,
    output logic                  out_valid,
    output logic [COORD_W-1:0]    out_x,
    output logic [COORD_W-1:0]    out_y,
    output logic                  frame_done,
    output logic [31:0]           frame_count,
    output logic                  busy,
    output logic                  sof_err
);

    localparam int BW = $clog2(LATENCY + 1);
    localparam logic [BW-1:0] LAT    = BW'(LATENCY);
    localparam logic [BW-1:0] LAT_M1 = BW'(LATENCY - 1);

    state_t                state, state_nxt;
    logic [BW-1:0]         beat_count;
    logic [BW-1:0]         flush_count;
    logic                  accept, flush_beat, beat;
    logic                  frame_clear, out_clear;
    logic [COORD_W-1:0]    in_x, in_y;
    logic                  in_last, out_last;
    logic                  at_origin;

    assign in_ready   = (state == FILL) || (state == RUN);
    assign busy       = (state != IDLE);
    assign accept     = in_valid && in_ready;
    assign flush_beat = (state == FLUSH);
    assign beat       = accept || flush_beat;
    assign at_origin  = (in_x == '0) && (in_y == '0);
    // The output raster wraps on its own after W*H results, so it only needs
    // clearing on a fresh start; clearing on a continuous re-arm would wipe the
    // coordinate of the final result still in flight.
    assign out_clear  = (state == IDLE) && start;

    always_comb begin
        state_nxt   = state;
        frame_clear = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = FILL;
                    frame_clear = 1'b1;
                end
            end
            FILL, RUN: begin
                if (accept && in_last)
                    state_nxt = FLUSH;
                else if (state == FILL && accept && beat_count == LAT_M1)
                    state_nxt = RUN;
            end
            FLUSH: begin
                if (flush_count == LAT_M1) begin
                    if (continuous) begin
                        state_nxt   = FILL;
                        frame_clear = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            beat_count  <= '0;
            flush_count <= '0;
            pipe_en     <= 1'b0;
            pipe_hsync  <= 1'b0;
            pipe_vsync  <= 1'b0;
            pipe_data   <= '0;
            out_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            sof_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            pipe_en    <= beat;
            pipe_hsync <= accept && (in_x == '0);
            pipe_vsync <= accept && at_origin;
            if (beat)
                pipe_data <= accept ? in_data : '0;
            out_valid  <= beat && (beat_count >= LAT);

            // The last real result leaves on the final flush beat's pipe_en.
            frame_done <= out_valid && out_last;
            if (out_valid && out_last)
                frame_count <= frame_count + 32'd1;

            if (frame_clear) begin
                beat_count  <= '0;
                flush_count <= '0;
            end else begin
                if (beat && beat_count != LAT)
                    beat_count <= beat_count + BW'(1);
                if (flush_beat)
                    flush_count <= flush_count + BW'(1);
            end

            if (state == IDLE && start)
                sof_err <= 1'b0;
            else if (accept && sof_mismatch(in_sof, at_origin))
                sof_err <= 1'b1;
        end
    end

    raster_counter #(
        .WIDTH   (FRAME_WIDTH),
        .HEIGHT  (FRAME_HEIGHT),
        .COORD_W (COORD_W)
    ) u_in_raster (
        .clk   (clk),
        .reset (reset),
        .clear (frame_clear),
        .inc   (accept),
        .x     (in_x),
        .y     (in_y),
        .last  (in_last)
    );

    raster_counter #(
        .WIDTH   (FRAME_WIDTH),
        .HEIGHT  (FRAME_HEIGHT),
        .COORD_W (COORD_W)
    ) u_out_raster (
        .clk   (clk),
        .reset (reset),
        .clear (out_clear),
        .inc   (out_valid),
        .x     (out_x),
        .y     (out_y),
        .last  (out_last)
    );

endmodule

// File: tb/tb_stream_controller.sv
// tb/tb_stream_controller.sv - directed self-checking bench for stream_controller (4x3 frame, latency 6)
module tb_stream_controller;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int LAT = 6;
    localparam int PS  = 24;
    localparam int CW  = 16;
    localparam int NB  = W * H + LAT;

    logic          clk = 1'b0;
    logic          reset, start, continuous, in_valid, in_sof;
    logic [PS-1:0] in_data;
    logic          in_ready, pipe_en, pipe_hsync, pipe_vsync, out_valid, frame_done, busy, sof_err;
    logic [PS-1:0] pipe_data;
    logic [CW-1:0] out_x, out_y;
    logic [31:0]   frame_count;

    int checks = 0;
    int errors = 0;

    stream_controller #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H),
        .LATENCY      (LAT),
        .PIXEL_SIZE   (PS),
        .COORD_W      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .continuous  (continuous),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sof      (in_sof),
        .in_data     (in_data),
        .pipe_en     (pipe_en),
        .pipe_hsync  (pipe_hsync),
        .pipe_vsync  (pipe_vsync),
        .pipe_data   (pipe_data),
        .out_valid   (out_valid),
        .out_x       (out_x),
        .out_y       (out_y),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .busy        (busy),
        .sof_err     (sof_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Beat log, filled on the falling edge whenever pipe_en is high.
    int            n = 0;
    logic          lg_h   [256];
    logic          lg_v   [256];
    logic          lg_ov  [256];
    logic          lg_rdy [256];
    logic [PS-1:0] lg_d   [256];
    logic [CW-1:0] lg_x   [256];
    logic [CW-1:0] lg_y   [256];
    int            lg_cyc [256];
    int            done_cnt = 0;
    int            done_cyc = 0;

    always @(negedge clk) begin
        if (pipe_en && n < 256) begin
            lg_h[n]   = pipe_hsync;
            lg_v[n]   = pipe_vsync;
            lg_ov[n]  = out_valid;
            lg_rdy[n] = in_ready;
            lg_d[n]   = pipe_data;
            lg_x[n]   = out_x;
            lg_y[n]   = out_y;
            lg_cyc[n] = cyc;
            n = n + 1;
        end
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_pixels(input int npix, input bit toggle, input logic [11:0] sof_mask,
                               output logic err_after_first);
        bit acc;
        int t;
        err_after_first = 1'b0;
        for (int p = 0; p < npix; p++) begin
            in_valid = 1'b1;
            in_sof   = sof_mask[p];
            in_data  = 24'hA00000 + PS'(p);
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 100) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL accept_timeout pixel=%0d got=no_accept want=accept", p);
            end
            if (p == 0) err_after_first = sof_err;
            if (toggle) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL frame_done_timeout got=%0d want=%0d", done_cnt, target);
        end
    endtask

    task automatic check_frame(input string name, input int base, input bit contiguous);
        logic          eh, ev, eov;
        logic [PS-1:0] ed;
        for (int k = 0; k < NB; k++) begin
            ev  = (k == 0);
            eh  = (k < W * H) && (k % W == 0);
            eov = (k >= LAT);
            ed  = (k < W * H) ? 24'hA00000 + PS'(k) : '0;
            checks++;
            if (lg_v[base+k] !== ev) begin errors++;
                $display("FAIL %s vsync beat=%0d got=%b want=%b", name, k, lg_v[base+k], ev); end
            checks++;
            if (lg_h[base+k] !== eh) begin errors++;
                $display("FAIL %s hsync beat=%0d got=%b want=%b", name, k, lg_h[base+k], eh); end
            checks++;
            if (lg_d[base+k] !== ed) begin errors++;
                $display("FAIL %s data beat=%0d got=%h want=%h", name, k, lg_d[base+k], ed); end
            checks++;
            if (lg_ov[base+k] !== eov) begin errors++;
                $display("FAIL %s out_valid beat=%0d got=%b want=%b", name, k, lg_ov[base+k], eov); end
            if (eov) begin
                checks++;
                if (lg_x[base+k] !== CW'((k - LAT) % W) || lg_y[base+k] !== CW'((k - LAT) / W)) begin
                    errors++;
                    $display("FAIL %s out_xy beat=%0d got=(%0d,%0d) want=(%0d,%0d)", name, k,
                             lg_x[base+k], lg_y[base+k], (k - LAT) % W, (k - LAT) / W);
                end
            end
        end
        if (contiguous) begin
            checks++;
            if (lg_cyc[base+NB-1] - lg_cyc[base] !== NB - 1) begin errors++;
                $display("FAIL %s contiguous got=%0d want=%0d", name,
                         lg_cyc[base+NB-1] - lg_cyc[base], NB - 1); end
        end
    endtask

    task automatic check_end(input string name, input int base, input int nbeats, input int fc);
        checks++;
        if (n - base !== nbeats) begin errors++;
            $display("FAIL %s beat_total got=%0d want=%0d", name, n - base, nbeats); end
        checks++;
        if (done_cyc !== lg_cyc[base+nbeats-1] + 1) begin errors++;
            $display("FAIL %s done_timing got=%0d want=%0d", name, done_cyc, lg_cyc[base+nbeats-1] + 1); end
        checks++;
        if (frame_count !== 32'(fc)) begin errors++;
            $display("FAIL %s frame_count got=%0d want=%0d", name, frame_count, fc); end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++;
            $display("FAIL %s idle_after got=busy%b/rdy%b want=0/0", name, busy, in_ready); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; continuous = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, pipe_en, pipe_hsync, pipe_vsync, out_valid, frame_done, busy, sof_err} !== 8'b0 ||
            pipe_data !== '0 || out_x !== '0 || out_y !== '0 || frame_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got=rdy%b en%b busy%b fc%0d want=all_zero",
                     in_ready, pipe_en, busy, frame_count);
        end
        start = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++;
            $display("FAIL reset_start_ignored got=busy%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        int   d0, base;
        logic e;
        d0 = done_cnt;
        do_start();
        send_pixels(7, 1'b0, 12'h001, e);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++;
            $display("FAIL mid_reset_idle got=busy%b/rdy%b want=0/0", busy, in_ready); end
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== d0 || frame_count !== 32'd0 || pipe_en !== 1'b0) begin errors++;
            $display("FAIL mid_reset_quiet got=done%0d/fc%0d want=%0d/0", done_cnt, frame_count, d0); end
        base = n;
        do_start();
        send_pixels(W * H, 1'b0, 12'h001, e);
        wait_done(d0 + 1);
        check_frame("after_reset", base, 1'b1);
        check_end("after_reset", base, NB, 1);
    endtask

    task automatic test_back_to_back();
        int   d0, base;
        logic e;
        d0 = done_cnt; base = n;
        do_start();
        send_pixels(W * H, 1'b0, 12'h001, e);
        wait_done(d0 + 1);
        check_frame("b2b", base, 1'b1);
        check_end("b2b", base, NB, 2);
    endtask

    task automatic test_toggle();
        int   d0, base;
        logic e;
        d0 = done_cnt; base = n;
        do_start();
        send_pixels(W * H, 1'b1, 12'h001, e);
        wait_done(d0 + 1);
        repeat (3) @(posedge clk);
        #1;
        check_frame("toggle", base, 1'b0);
        check_end("toggle", base, NB, 3);
    endtask

    task automatic test_sof_err();
        int   d0, base;
        logic e;
        d0 = done_cnt; base = n;
        do_start();
        send_pixels(W * H, 1'b0, 12'b0000_0010_0000, e);
        checks++;
        if (e !== 1'b1) begin errors++;
            $display("FAIL sof_err_first got=%b want=1", e); end
        wait_done(d0 + 1);
        check_frame("sof", base, 1'b1);
        check_end("sof", base, NB, 4);
        checks++;
        if (sof_err !== 1'b1) begin errors++;
            $display("FAIL sof_err_sticky got=%b want=1", sof_err); end
        do_start();
        checks++;
        if (sof_err !== 1'b0) begin errors++;
            $display("FAIL sof_err_clear got=%b want=0", sof_err); end
        send_pixels(W * H, 1'b0, 12'h001, e);
        wait_done(d0 + 2);
        checks++;
        if (sof_err !== 1'b0 || frame_count !== 32'd5) begin errors++;
            $display("FAIL sof_clean_frame got=err%b/fc%0d want=0/5", sof_err, frame_count); end
    endtask

    task automatic test_continuous();
        int   d0, base;
        logic e;
        d0 = done_cnt; base = n;
        continuous = 1'b1;
        do_start();
        send_pixels(W * H, 1'b0, 12'h001, e);
        send_pixels(W * H, 1'b0, 12'h001, e);
        continuous = 1'b0;
        wait_done(d0 + 2);
        repeat (10) @(posedge clk);
        #1;
        check_frame("cont_f1", base, 1'b1);
        check_frame("cont_f2", base + NB, 1'b1);
        checks++;
        if (lg_rdy[base+NB-2] !== 1'b0 || lg_rdy[base+NB-1] !== 1'b1) begin errors++;
            $display("FAIL cont_rearm got=%b%b want=01", lg_rdy[base+NB-2], lg_rdy[base+NB-1]); end
        checks++;
        if (done_cnt !== d0 + 2) begin errors++;
            $display("FAIL cont_done_pulses got=%0d want=%0d", done_cnt - d0, 2); end
        check_end("cont", base, 2 * NB, 7);
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_back_to_back();
        test_toggle();
        test_sof_err();
        test_continuous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
